// File: rtl/id_stage.sv
// Instruction-decode stage: register-file addressing, immediate/control decode,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
    parameter int unsigned RFW = 5,
    parameter int unsigned DW  = 32,
    parameter int unsigned IW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           if_valid,
    input  logic [IW-1:0]  if_inst,
    input  logic [31:0]    if_pc,
    input  logic           flush,
    output logic [RFW-1:0] rf_reg1,
    output logic [RFW-1:0] rf_reg2,
    input  logic [DW-1:0]  rf_reg1data,
    input  logic [DW-1:0]  rf_reg2data,
    output logic           stall,
    output logic           ex_valid,
    output logic [IW-1:0]  ex_inst,
    output logic [31:0]    ex_pc,
    output logic [DW-1:0]  ex_rs1data,
    output logic [DW-1:0]  ex_rs2data,
    output logic [31:0]    ex_imm,
    output logic [RFW-1:0] ex_rd,
    output logic           ex_regwrite,
    output logic           ex_memread,
    output logic           ex_memwrite,
    output logic           ex_illegal,
    output logic [15:0]    stall_count
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] CNT_MAX = '1;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    logic [6:0]     opcode;
    logic [RFW-1:0] rd;
    logic           fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j;
    logic           illegal;
    logic           uses_rs1, uses_rs2;
    logic           regwrite, memread, memwrite;
    logic [31:0]    imm;
    logic           hazard;

    assign opcode  = if_inst[6:0];
    assign rd      = RFW'(if_inst[11:7]);
    assign rf_reg1 = RFW'(if_inst[19:15]);
    assign rf_reg2 = RFW'(if_inst[24:20]);

    // Format classification; anything unlisted is illegal.
    always_comb begin
        fmt_r   = 1'b0;
        fmt_i   = 1'b0;
        fmt_s   = 1'b0;
        fmt_b   = 1'b0;
        fmt_u   = 1'b0;
        fmt_j   = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_R:                      fmt_r   = 1'b1;
            OP_IMM, OP_LOAD, OP_JALR:  fmt_i   = 1'b1;
            OP_STORE:                  fmt_s   = 1'b1;
            OP_BRANCH:                 fmt_b   = 1'b1;
            OP_LUI, OP_AUIPC:          fmt_u   = 1'b1;
            OP_JAL:                    fmt_j   = 1'b1;
            default:                   illegal = 1'b1;
        endcase
    end

    // Immediate generation, sign-extended from inst[31].
    always_comb begin
        imm = 32'h0;
        if (fmt_i) begin
            imm = {{20{if_inst[31]}}, if_inst[31:20]};
        end else if (fmt_s) begin
            imm = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
        end else if (fmt_b) begin
            imm = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                   if_inst[30:25], if_inst[11:8], 1'b0};
        end else if (fmt_u) begin
            imm = {if_inst[31:12], 12'h000};
        end else if (fmt_j) begin
            imm = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                   if_inst[20], if_inst[30:21], 1'b0};
        end
    end

    assign uses_rs1 = fmt_r | fmt_i | fmt_s | fmt_b;
    assign uses_rs2 = fmt_r | fmt_s | fmt_b;
    assign regwrite = (fmt_r | fmt_i | fmt_u | fmt_j) && (rd != '0);
    assign memread  = (opcode == OP_LOAD);
    assign memwrite = (opcode == OP_STORE);

    // Load in EX whose destination feeds an operand of the instruction in ID.
    assign hazard = if_valid && ex_valid && ex_memread && (ex_rd != '0) &&
                    ((uses_rs1 && (rf_reg1 == ex_rd)) ||
                     (uses_rs2 && (rf_reg2 == ex_rd)));

    assign stall = hazard && !flush;

    // ID/EX register: reset, then flush/stall bubble, then normal capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_inst     <= '0;
            ex_pc       <= '0;
            ex_rs1data  <= '0;
            ex_rs2data  <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_illegal  <= 1'b0;
            stall_count <= '0;
        end else begin
            if (flush || hazard) begin
                ex_valid    <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_memwrite <= 1'b0;
                ex_illegal  <= 1'b0;
            end else begin
                ex_valid    <= if_valid;
                ex_inst     <= if_inst;
                ex_pc       <= if_pc;
                ex_rs1data  <= rf_reg1data;
                ex_rs2data  <= rf_reg2data;
                ex_imm      <= imm;
                ex_rd       <= rd;
                ex_regwrite <= if_valid && regwrite && !illegal;
                ex_memread  <= if_valid && memread;
                ex_memwrite <= if_valid && memwrite;
                ex_illegal  <= if_valid && illegal;
            end
            if (stall && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, hand-written hazard
// and flush sequences, and randomized traffic against a behavioural model.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        flush;
    logic [4:0]  rf_reg1, rf_reg2;
    logic [31:0] rf_reg1data, rf_reg2data;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_inst, ex_pc, ex_rs1data, ex_rs2data, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_illegal;
    logic [15:0] stall_count;

    id_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst),
        .if_pc(if_pc), .flush(flush), .rf_reg1(rf_reg1), .rf_reg2(rf_reg2),
        .rf_reg1data(rf_reg1data), .rf_reg2data(rf_reg2data), .stall(stall),
        .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc),
        .ex_rs1data(ex_rs1data), .ex_rs2data(ex_rs2data), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_illegal(ex_illegal),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file environment: combinational read, x0 reads zero.
    logic [31:0] rf_mem [32];
    assign rf_reg1data = rf_mem[rf_reg1];
    assign rf_reg2data = rf_mem[rf_reg2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        legal;
        logic        u1, u2;
        logic        rw, mr, mw;
        logic [31:0] imm;
    } dec_t;

    // Reference decode computed from the field rules with integer arithmetic.
    function automatic dec_t decode(input logic [31:0] i);
        dec_t d;
        int   op;
        int   rdn;
        int   neg;
        op  = int'(i[6:0]);
        rdn = int'(i[11:7]);
        neg = int'(i[31]);
        d.legal = 1'b1; d.u1 = 1'b0; d.u2 = 1'b0; d.rw = 1'b0;
        d.imm = 32'h0;
        case (op)
            'h33: begin d.u1 = 1'b1; d.u2 = 1'b1; d.rw = 1'b1; end
            'h13, 'h03, 'h67: begin
                d.u1 = 1'b1; d.rw = 1'b1;
                d.imm = 32'(int'(i[31:20]) - neg * 4096);
            end
            'h23: begin
                d.u1 = 1'b1; d.u2 = 1'b1;
                d.imm = 32'(int'(i[31:25]) * 32 + int'(i[11:7]) - neg * 4096);
            end
            'h63: begin
                d.u1 = 1'b1; d.u2 = 1'b1;
                d.imm = 32'(int'(i[7]) * 2048 + int'(i[30:25]) * 32 +
                            int'(i[11:8]) * 2 - neg * 4096);
            end
            'h37, 'h17: begin
                d.rw = 1'b1;
                d.imm = 32'(longint'(i[31:12]) * 4096);
            end
            'h6F: begin
                d.rw = 1'b1;
                d.imm = 32'(int'(i[19:12]) * 4096 + int'(i[20]) * 2048 +
                            int'(i[30:21]) * 2 - neg * 1048576);
            end
            default: d.legal = 1'b0;
        endcase
        d.rw = d.rw && d.legal && (rdn != 0);
        d.mr = (op == 'h03);
        d.mw = (op == 'h23);
        return d;
    endfunction

    // Behavioural model of the ID/EX contents.
    logic        m_valid, m_rw, m_mr, m_mw, m_ill;
    logic [31:0] m_inst, m_pc, m_rs1d, m_rs2d, m_imm;
    logic [4:0]  m_rd;
    int          m_cnt;
    logic        pre_ok;
    logic        seen_stall;

    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic fl, input logic r);
        dec_t d;
        logic hz, exp_stall;
        rst = r; if_valid = v; if_inst = inst; if_pc = pc; flush = fl;
        #1;
        d  = decode(inst);
        hz = v && m_valid && m_mr && (m_rd != 5'd0) &&
             ((d.u1 && inst[19:15] == m_rd) || (d.u2 && inst[24:20] == m_rd));
        exp_stall  = hz && !fl;
        seen_stall = stall;
        if (pre_ok) begin
            chk("stall", {31'b0, stall}, {31'b0, exp_stall});
            chk("rf_reg1", {27'b0, rf_reg1}, {27'b0, inst[19:15]});
            chk("rf_reg2", {27'b0, rf_reg2}, {27'b0, inst[24:20]});
        end
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_ill = 0;
            m_inst = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0; m_rd = 0;
            m_cnt = 0;
        end else if (fl || hz) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_ill = 0;
            if (!fl && m_cnt < 65535) m_cnt++;
        end else begin
            m_valid = v;
            m_inst  = inst;
            m_pc    = pc;
            m_rs1d  = rf_mem[inst[19:15]];
            m_rs2d  = rf_mem[inst[24:20]];
            m_imm   = d.imm;
            m_rd    = inst[11:7];
            m_rw    = v && d.rw;
            m_mr    = v && d.mr;
            m_mw    = v && d.mw;
            m_ill   = v && !d.legal;
        end
        #1;
        pre_ok = 1'b1;
        chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
        chk("ex_regwrite", {31'b0, ex_regwrite}, {31'b0, m_rw});
        chk("ex_memread", {31'b0, ex_memread}, {31'b0, m_mr});
        chk("ex_memwrite", {31'b0, ex_memwrite}, {31'b0, m_mw});
        chk("stall_count", {16'b0, stall_count}, 32'(m_cnt));
        if (m_valid) begin
            chk("ex_inst", ex_inst, m_inst);
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_rs1data", ex_rs1data, m_rs1d);
            chk("ex_rs2data", ex_rs2data, m_rs2d);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_rd", {27'b0, ex_rd}, {27'b0, m_rd});
            chk("ex_illegal", {31'b0, ex_illegal}, {31'b0, m_ill});
        end
        @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw, mr, mw, ill;
    } vec_t;

    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] LW_X3   = 32'h00012183;
    localparam logic [31:0] ADD_X3  = 32'h00118233;
    localparam logic [31:0] LW_X0   = 32'h00012003;
    localparam logic [31:0] ADD_X0  = 32'h00100233;
    localparam logic [31:0] LUI_X3  = 32'h000181B7;
    localparam logic [31:0] BEQ     = 32'h00208463;
    localparam logic [31:0] SW      = 32'h00512423;

    logic [6:0] ops [10];

    initial begin
        vec_t vt [10];
        logic [31:0] ri;
        logic        rv, rf, rr;
        logic        hold;

        vt[0] = '{"addi",  32'hFFD08293, 32'hFFFFFFFD, 5'd5,  1, 0, 0, 0};
        vt[1] = '{"beq",   32'hFE000EE3, 32'hFFFFFFFC, 5'd29, 0, 0, 0, 0};
        vt[2] = '{"jal",   32'h0080006F, 32'h00000008, 5'd0,  0, 0, 0, 0};
        vt[3] = '{"ill7f", 32'h00000FFF, 32'h00000000, 5'd31, 0, 0, 0, 1};
        vt[4] = '{"lw",    LW_X3,        32'h00000000, 5'd3,  1, 1, 0, 0};
        vt[5] = '{"sw",    SW,           32'h00000008, 5'd8,  0, 0, 1, 0};
        vt[6] = '{"lui",   32'h123453B7, 32'h12345000, 5'd7,  1, 0, 0, 0};
        vt[7] = '{"add",   ADD_X3,       32'h00000000, 5'd4,  1, 0, 0, 0};
        vt[8] = '{"auipc", 32'hFFFFF017, 32'hFFFFF000, 5'd0,  0, 0, 0, 0};
        vt[9] = '{"jalr",  32'h000080E7, 32'h00000000, 5'd1,  1, 0, 0, 0};

        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

        rf_mem[0] = 32'h0;
        rf_mem[1] = 32'd10;
        for (int k = 2; k < 32; k++) rf_mem[k] = $urandom;
        pre_ok = 1'b0;
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_ill = 0; m_rd = 0; m_cnt = 0;
        rst = 1'b1; if_valid = 1'b0; if_inst = NOP; if_pc = 0; flush = 1'b0;
        @(negedge clk);

        // Reset held two cycles
        step(0, NOP, 0, 0, 1);
        step(0, NOP, 0, 0, 1);
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_ex_regwrite", {31'b0, ex_regwrite}, 32'd0);
        chk("rst_stall_count", {16'b0, stall_count}, 32'd0);
        step(0, NOP, 0, 0, 0);
        chk("rst_stall", {31'b0, seen_stall}, 32'd0);

        // Directed decode vectors, each isolated by a NOP
        for (int k = 0; k < 10; k++) begin
            step(1, NOP, 32'h40, 0, 0);
            step(1, vt[k].inst, 32'h44 + 32'(k * 4), 0, 0);
            chk({vt[k].name, "_imm"}, ex_imm, vt[k].imm);
            chk({vt[k].name, "_rd"}, {27'b0, ex_rd}, {27'b0, vt[k].rd});
            chk({vt[k].name, "_regwrite"}, {31'b0, ex_regwrite}, {31'b0, vt[k].rw});
            chk({vt[k].name, "_memread"}, {31'b0, ex_memread}, {31'b0, vt[k].mr});
            chk({vt[k].name, "_memwrite"}, {31'b0, ex_memwrite}, {31'b0, vt[k].mw});
            chk({vt[k].name, "_illegal"}, {31'b0, ex_illegal}, {31'b0, vt[k].ill});
            chk({vt[k].name, "_valid"}, {31'b0, ex_valid}, 32'd1);
        end
        chk("addi_rs1data", 32'd10, 32'd10 & rf_mem[1]);
        step(1, 32'hFFD08293, 32'h80, 0, 0);
        chk("addi_ex_rs1data", ex_rs1data, 32'd10);

        // Load-use: one stall, one bubble, ADD follows
        step(1, LW_X3, 32'h100, 0, 0);
        step(1, ADD_X3, 32'h104, 0, 0);
        chk("lu_stall", {31'b0, seen_stall}, 32'd1);
        chk("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
        chk("lu_count", {16'b0, stall_count}, 32'd1);
        step(1, ADD_X3, 32'h104, 0, 0);
        chk("lu_release", {31'b0, seen_stall}, 32'd0);
        chk("lu_add_inst", ex_inst, ADD_X3);
        chk("lu_add_valid", {31'b0, ex_valid}, 32'd1);

        // No false hazards on x0 or on an unused rs1 field
        step(1, LW_X0, 32'h200, 0, 0);
        step(1, ADD_X0, 32'h204, 0, 0);
        chk("x0_nostall", {31'b0, seen_stall}, 32'd0);
        step(1, LW_X3, 32'h208, 0, 0);
        step(1, LUI_X3, 32'h20C, 0, 0);
        chk("lui_nostall", {31'b0, seen_stall}, 32'd0);

        // Flush with branch and with store in ID
        step(1, BEQ, 32'h300, 1, 0);
        chk("flush_beq_valid", {31'b0, ex_valid}, 32'd0);
        step(1, SW, 32'h304, 1, 0);
        chk("flush_sw_memwrite", {31'b0, ex_memwrite}, 32'd0);

        // Flush coincident with a load-use hazard
        step(1, LW_X3, 32'h400, 0, 0);
        step(1, ADD_X3, 32'h404, 1, 0);
        chk("flhz_stall", {31'b0, seen_stall}, 32'd0);
        chk("flhz_valid", {31'b0, ex_valid}, 32'd0);
        chk("flhz_count", {16'b0, stall_count}, 32'd1);

        // Reset asserted during a stall clears the load and releases the stall
        step(1, LW_X3, 32'h500, 0, 0);
        step(1, ADD_X3, 32'h504, 0, 1);
        chk("rststall_stall", {31'b0, seen_stall}, 32'd1);
        chk("rststall_memread", {31'b0, ex_memread}, 32'd0);
        chk("rststall_count", {16'b0, stall_count}, 32'd0);
        step(1, ADD_X3, 32'h504, 0, 0);
        chk("rststall_release", {31'b0, seen_stall}, 32'd0);

        // Randomized traffic; IF holds its instruction while stalled
        hold = 1'b0;
        ri = NOP;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                ri = $urandom;
                ri[6:0]   = ops[$urandom_range(0, 9)];
                ri[11:7]  = 5'($urandom_range(0, 3));
                ri[19:15] = 5'($urandom_range(0, 3));
                ri[24:20] = 5'($urandom_range(0, 3));
                rv = ($urandom_range(0, 7) != 0);
            end
            rf = ($urandom_range(0, 7) == 0);
            rr = ($urandom_range(0, 63) == 0);
            step(rv, ri, 32'h1000 + 32'(n * 4), rf, rr);
            hold = seen_stall;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
